// File: rtl/overlay_blitter.sv
// rtl/overlay_blitter.sv - VGA write-port overlay: registered pass-through or 1bpp bitmap sweep.
// Optional feature macro: BLIT_TRANSPARENT_EN (clear bitmap bits are not plotted).
module overlay_blitter #(
  parameter int                       BMP_W  = 44,
  parameter int                       BMP_H  = 5,
  parameter int                       ORG_X  = 75,
  parameter int                       ORG_Y  = 75,
  parameter logic [23:0]              FG     = 24'h000000,
  parameter logic [23:0]              BG     = 24'hFFFFFF,
  parameter logic [BMP_W*BMP_H-1:0]   BITMAP = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  pass_x,
  input  logic [6:0]  pass_y,
  input  logic [23:0] pass_colour,
  input  logic        pass_plot,
  output logic        busy,
  output logic        done,
  output logic        owned,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [23:0] vga_colour,
  output logic        vga_plot
);

  localparam int          NPIX   = BMP_W * BMP_H;
  localparam int          IW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [7:0]  LAST_X = 8'(BMP_W - 1);
  localparam logic [6:0]  LAST_Y = 7'(BMP_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cx_q, cx_d;
  logic [6:0]    cy_q, cy_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    x_d;
  logic [6:0]    y_d;
  logic [23:0]   col_d;
  logic          plot_d, busy_d, done_d, bit_set;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ptr_d   = ptr_q;
    x_d     = vga_x;
    y_d     = vga_y;
    col_d   = vga_colour;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bit_set = BITMAP[ptr_q];
    case (state_q)
      S_IDLE: begin
        x_d    = pass_x;
        y_d    = pass_y;
        col_d  = pass_colour;
        plot_d = pass_plot;
        if (start) begin
          state_d = S_DRAW;
          cx_d    = '0;
          cy_d    = '0;
          ptr_d   = '0;
        end
      end
      S_DRAW: begin
        x_d    = 8'(ORG_X) + cx_q;
        y_d    = 7'(ORG_Y) + cy_q;
        busy_d = 1'b1;
`ifdef BLIT_TRANSPARENT_EN
        col_d  = FG;
        plot_d = bit_set;
`else
        col_d  = bit_set ? FG : BG;
        plot_d = 1'b1;
`endif
        ptr_d  = ptr_q + IW'(1);
        if (cx_q == LAST_X) begin
          cx_d = '0;
          if (cy_q == LAST_Y) begin
            // Last pixel is on its way out this edge; park the pointer in range.
            state_d = S_HOLD;
            done_d  = 1'b1;
            ptr_d   = '0;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (start) begin
          state_d = S_DRAW;
          cx_d    = '0;
          cy_d    = '0;
          ptr_d   = '0;
        end else if (clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      ptr_q      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      owned      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ptr_q      <= ptr_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= col_d;
      vga_plot   <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
      owned      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_overlay_blitter.sv
// tb/tb_overlay_blitter.sv - randomized bench for overlay_blitter against a cycle-level reference model.
module tb_overlay_blitter;

  localparam int          W    = 44;
  localparam int          H    = 5;
  localparam int          NPIX = W * H;
  localparam logic [23:0] FGC  = 24'h000000;
  localparam logic [23:0] BGC  = 24'hFFFFFF;
  localparam logic [NPIX-1:0] TB_BMP = (220'd1 << 219) | 220'd1;

  logic        clk = 1'b0;
  logic        reset_n, start, clear, pass_plot;
  logic [7:0]  pass_x;
  logic [6:0]  pass_y;
  logic [23:0] pass_colour;
  logic        busy, done, owned, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_colour;

  overlay_blitter #(
    .BMP_W(W), .BMP_H(H), .ORG_X(75), .ORG_Y(75), .FG(FGC), .BG(BGC), .BITMAP(TB_BMP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .pass_x(pass_x), .pass_y(pass_y), .pass_colour(pass_colour), .pass_plot(pass_plot),
    .busy(busy), .done(done), .owned(owned),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mode 0 = idle, 1 = sweeping pixel k, 2 = holding the finished banner.
  logic [NPIX-1:0] bmp = TB_BMP;
  int          mode = 0;
  int          k = 0;
  logic [7:0]  ex;
  logic [6:0]  ey;
  logic [23:0] ec;
  logic        ep, ebusy, edone, eowned;

  task automatic model_edge();
    if (!reset_n) begin
      mode = 0; k = 0;
      ex = '0; ey = '0; ec = '0; ep = 0; ebusy = 0; edone = 0;
    end else begin
      case (mode)
        0: begin
          ex = pass_x; ey = pass_y; ec = pass_colour; ep = pass_plot;
          ebusy = 0; edone = 0;
          if (start) begin mode = 1; k = 0; end
        end
        1: begin
          ex = 8'(75 + k % W);
          ey = 7'(75 + k / W);
`ifdef BLIT_TRANSPARENT_EN
          ec = FGC; ep = bmp[k];
`else
          ec = bmp[k] ? FGC : BGC; ep = 1'b1;
`endif
          ebusy = 1;
          edone = (k == NPIX - 1);
          k++;
          if (k == NPIX) mode = 2;
        end
        default: begin
          ep = 0; ebusy = 0; edone = 0;
          if (start) begin mode = 1; k = 0; end
          else if (clear) mode = 0;
        end
      endcase
    end
    eowned = (mode != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("vga_x", 32'(vga_x), 32'(ex));
    check_eq("vga_y", 32'(vga_y), 32'(ey));
    check_eq("vga_colour", 32'(vga_colour), 32'(ec));
    check_eq("vga_plot", 32'(vga_plot), 32'(ep));
    check_eq("busy", 32'(busy), 32'(ebusy));
    check_eq("done", 32'(done), 32'(edone));
    check_eq("owned", 32'(owned), 32'(eowned));
  endtask

  task automatic rand_pass(input logic plot_on);
    pass_x      = 8'($urandom_range(0, 159));
    pass_y      = 7'($urandom_range(0, 119));
    pass_colour = 24'($urandom);
    pass_plot   = plot_on;
  endtask

  // One start pulse, then the whole sweep with the pass port actively writing.
  task automatic run_sweep(input string tag);
    int n_plot, n_done, n_busy, guard;
    start = 1; clear = 0; rand_pass(1);
    step();
    start = 0;
    n_plot = 0; n_done = 0; n_busy = 0; guard = 0;
    do begin
      rand_pass(1);
      start = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1));
      step();
      if (guard == 0) begin
        check_eq({tag, "_first_x"}, 32'(vga_x), 32'd75);
        check_eq({tag, "_first_y"}, 32'(vga_y), 32'd75);
      end
      n_plot += int'(vga_plot);
      n_done += int'(done);
      n_busy += int'(busy);
      guard++;
    end while (mode == 1 && guard < 400);
    start = 0; clear = 0;
    check_eq({tag, "_len"}, 32'(guard), 32'(NPIX));
    check_eq({tag, "_last_x"}, 32'(vga_x), 32'd118);
    check_eq({tag, "_last_y"}, 32'(vga_y), 32'd79);
    check_eq({tag, "_last_done"}, 32'(done), 32'd1);
    check_eq({tag, "_ndone"}, 32'(n_done), 32'd1);
    check_eq({tag, "_nbusy"}, 32'(n_busy), 32'(NPIX));
`ifdef BLIT_TRANSPARENT_EN
    check_eq({tag, "_nplot"}, 32'(n_plot), 32'd2);
`else
    check_eq({tag, "_nplot"}, 32'(n_plot), 32'(NPIX));
`endif
  endtask

  initial begin
    reset_n = 0; start = 0; clear = 0; rand_pass(1);
    step(); step();
    check_eq("reset_plot", 32'(vga_plot), 32'd0);
    reset_n = 1;

    // Idle pass-through, including the fixed pattern and plot toggling.
    pass_x = 8'd10; pass_y = 7'd20; pass_colour = 24'h00FF00; pass_plot = 1;
    step();
    check_eq("pass_fixed_x", 32'(vga_x), 32'd10);
    check_eq("pass_fixed_colour", 32'(vga_colour), 32'h00FF00);
    for (int i = 0; i < 30; i++) begin
      rand_pass(1'(i % 2));
      step();
    end

    run_sweep("sweep1");
    for (int i = 0; i < 8; i++) begin rand_pass(1); step(); end
    clear = 1; rand_pass(1); step();
    clear = 0;
    check_eq("after_clear_owned", 32'(owned), 32'd0);
    for (int i = 0; i < 6; i++) begin rand_pass(1); step(); end

    // Reset mid-sweep abandons it; the next sweep restarts at the origin.
    start = 1; step(); start = 0;
    for (int i = 0; i < 57; i++) begin rand_pass(1); step(); end
    reset_n = 0; step();
    check_eq("midreset_busy", 32'(busy), 32'd0);
    check_eq("midreset_owned", 32'(owned), 32'd0);
    step(); reset_n = 1;
    run_sweep("sweep2");

    // start and clear together in HOLD: start wins, no idle gap.
    step();
    start = 1; clear = 1; step();
    check_eq("restart_owned", 32'(owned), 32'd1);
    start = 0; clear = 0;
    for (int i = 0; i < NPIX + 3; i++) begin rand_pass(1); step(); end

    for (int i = 0; i < 3000; i++) begin
      rand_pass(1'($urandom_range(0, 1)));
      start   = ($urandom_range(0, 63) == 0);
      clear   = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
